// File: rtl/tank_pkg.sv
// Shared types and constants for the tank sprite fetch path.
package tank_pkg;

    // Facing direction of the tank; encoding matches the tank_dir input.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Default sprite edge length in pixels; must be a power of two.
    localparam int TANK_SPRITE_SIZE = 32;

    // Width of screen coordinates.
    localparam int TANK_COORD_W = 10;

endpackage

// File: rtl/tank_sprite_addr.sv
// Rotates sprite-local coordinates into a sprite ROM address.
// Because the sprite edge is a power of two, S-1-x is simply ~x.
module tank_sprite_addr
    import tank_pkg::*;
#(
    parameter int  SPRITE_SIZE = TANK_SPRITE_SIZE,
    localparam int CW          = $clog2(SPRITE_SIZE)
) (
    input  logic [CW-1:0]   i_lx,
    input  logic [CW-1:0]   i_ly,
    input  logic [1:0]      i_dir,
    output logic [2*CW-1:0] o_rom_addr
);

    logic [CW-1:0] w_row;
    logic [CW-1:0] w_col;

    // Pick the ROM row/column that corresponds to this screen pixel for each facing.
    always_comb begin
        w_row = i_ly;
        w_col = i_lx;
        case (dir_t'(i_dir))
            DIR_UP: begin
                w_row = i_ly;
                w_col = i_lx;
            end
            DIR_RIGHT: begin
                w_row = ~i_lx;
                w_col = i_ly;
            end
            DIR_DOWN: begin
                w_row = ~i_ly;
                w_col = ~i_lx;
            end
            DIR_LEFT: begin
                w_row = i_lx;
                w_col = ~i_ly;
            end
            default: begin
                w_row = i_ly;
                w_col = i_lx;
            end
        endcase
    end

    // row*S + col is a plain concatenation for a power-of-two edge.
    assign o_rom_addr = {w_row, w_col};

endmodule

// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch: frame-latched position/direction, ROM address generation,
// a two-stage pixel pipeline matching the 1-cycle ROM, and the damage flash.
module tank_sprite_fetch
    import tank_pkg::*;
#(
    parameter int         SPRITE_SIZE       = TANK_SPRITE_SIZE,
    parameter logic [3:0] TRANSPARENT_INDEX = 4'h0,
    parameter logic [3:0] FLASH_INDEX       = 4'h7,
    parameter int         FLASH_FRAMES      = 15,
    localparam int        CW                = $clog2(SPRITE_SIZE),
    localparam int        AW                = 2 * CW
) (
    input  logic          i_vga_clk,
    input  logic          i_reset,
    input  logic          i_frame_start,
    input  logic [9:0]    i_tank_x,
    input  logic [9:0]    i_tank_y,
    input  logic [1:0]    i_tank_dir,
    input  logic          i_hit_flash,
    input  logic [9:0]    i_draw_x,
    input  logic [9:0]    i_draw_y,
    input  logic          i_blank,
    output logic [AW-1:0] o_rom_addr,
    input  logic [3:0]    i_rom_q,
    output logic [3:0]    o_pix_index,
    output logic          o_pix_hit
);

    localparam logic [10:0] SIZE_EXT   = 11'(SPRITE_SIZE);
    localparam logic [3:0]  FLASH_LOAD = 4'(FLASH_FRAMES);

    logic [9:0]  r_sx;
    logic [9:0]  r_sy;
    logic [1:0]  r_dir;
    logic        r_armed;
    logic [3:0]  r_fc;
    logic        r_stage1;
    logic [3:0]  r_pix_index;
    logic        r_pix_hit;

    logic [10:0] w_lx;
    logic [10:0] w_ly;
    logic        w_inside;
    logic        w_flash_on;
    logic        w_visible;

    // Sprite-local offsets, one bit wider so pixels left/above the sprite go negative.
    assign w_lx = {1'b0, i_draw_x} - {1'b0, r_sx};
    assign w_ly = {1'b0, i_draw_y} - {1'b0, r_sy};

    // Unsigned compare against the edge length also rejects anything past the
    // right/bottom edge, so a sprite hanging off-screen never wraps around.
    assign w_inside = !w_lx[10] && !w_ly[10] && (w_lx < SIZE_EXT) && (w_ly < SIZE_EXT);

    assign w_flash_on = r_fc[0];

    tank_sprite_addr #(
        .SPRITE_SIZE (SPRITE_SIZE)
    ) u_addr (
        .i_lx       (w_lx[CW-1:0]),
        .i_ly       (w_ly[CW-1:0]),
        .i_dir      (r_dir),
        .o_rom_addr (o_rom_addr)
    );

    // Shadow the tank pose once per frame; r_armed keeps output dark after reset until then.
    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_dir   <= DIR_UP;
            r_armed <= 1'b0;
        end else if (i_frame_start) begin
            r_sx    <= i_tank_x;
            r_sy    <= i_tank_y;
            r_dir   <= i_tank_dir;
            r_armed <= 1'b1;
        end
    end

    // Damage flash counter: a hit reloads it, each frame boundary counts it down.
    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_fc <= '0;
        end else if (i_hit_flash) begin
            r_fc <= FLASH_LOAD;
        end else if (i_frame_start && (r_fc != 4'd0)) begin
            r_fc <= r_fc - 4'd1;
        end
    end

    // Stage 1 carries "this pixel belongs to the sprite" alongside the ROM read.
    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_stage1 <= 1'b0;
        end else begin
            r_stage1 <= w_inside && i_blank && r_armed;
        end
    end

    assign w_visible = r_stage1 && (i_rom_q != TRANSPARENT_INDEX);

    // Stage 2 merges the ROM data with transparency and the flash substitution.
    always_ff @(posedge i_vga_clk) begin
        if (i_reset) begin
            r_pix_hit   <= 1'b0;
            r_pix_index <= TRANSPARENT_INDEX;
        end else begin
            r_pix_hit <= w_visible;
            if (!w_visible) begin
                r_pix_index <= TRANSPARENT_INDEX;
            end else if (w_flash_on) begin
                r_pix_index <= FLASH_INDEX;
            end else begin
                r_pix_index <= i_rom_q;
            end
        end
    end

    assign o_pix_hit   = r_pix_hit;
    assign o_pix_index = r_pix_index;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Testbench for tank_sprite_fetch: a behavioural sprite ROM, a reference
// model of the pose shadows and flash counter, and a pixel scoreboard.
module tb_tank_sprite_fetch;

    localparam int S = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       frameStart;
    logic       hitFlash;
    logic       blank;
    logic [9:0] tankX;
    logic [9:0] tankY;
    logic [1:0] tankDir;
    logic [9:0] drawX;
    logic [9:0] drawY;
    logic [9:0] romAddr;
    logic [3:0] romQ;
    logic [3:0] pixIndex;
    logic       pixHit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       valid;
        logic [3:0] rom;
        logic       flash;
    } entry_t;

    entry_t sb[$];

    int         mSx    = 0;
    int         mSy    = 0;
    int         mDir   = 0;
    int         mFc    = 0;
    bit         mArmed = 1'b0;
    logic [9:0] lastAddr;

    tank_sprite_fetch dut (
        .i_vga_clk     (clk),
        .i_reset       (reset),
        .i_frame_start (frameStart),
        .i_tank_x      (tankX),
        .i_tank_y      (tankY),
        .i_tank_dir    (tankDir),
        .i_hit_flash   (hitFlash),
        .i_draw_x      (drawX),
        .i_draw_y      (drawY),
        .i_blank       (blank),
        .o_rom_addr    (romAddr),
        .i_rom_q       (romQ),
        .o_pix_index   (pixIndex),
        .o_pix_hit     (pixHit)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: a scrambled pattern with some transparent entries.
    function automatic logic [3:0] romData(input logic [9:0] a);
        int v;
        v = int'(a);
        return 4'((v * 5 + 3) ^ (v >> 6));
    endfunction

    // External synchronous ROM, one cycle of read latency.
    always @(posedge clk) romQ <= romData(romAddr);

    function automatic int modelAddr(input int dx, input int dy);
        int lx, ly, row, col;
        lx = (dx - mSx) & (S - 1);
        ly = (dy - mSy) & (S - 1);
        case (mDir)
            1:       begin row = S - 1 - lx; col = ly;         end
            2:       begin row = S - 1 - ly; col = S - 1 - lx; end
            3:       begin row = lx;         col = S - 1 - ly; end
            default: begin row = ly;         col = lx;         end
        endcase
        return row * S + col;
    endfunction

    function automatic bit modelInside(input int dx, input int dy);
        int lx, ly;
        lx = dx - mSx;
        ly = dy - mSy;
        return (lx >= 0) && (lx < S) && (ly >= 0) && (ly < S);
    endfunction

    // Drive one pixel cycle, queue its expected pixel, check the address, advance the model.
    task automatic applyStimulus(input int dx, input int dy, input bit bl,
                                 input bit fs, input bit hf, input bit rst);
        entry_t e;
        int     expAddr;
        drawX      = 10'(dx);
        drawY      = 10'(dy);
        blank      = bl;
        frameStart = fs;
        hitFlash   = hf;
        reset      = rst;
        if (sb.size() > 0) begin
            sb[sb.size()-1].flash = mFc[0];
            if (rst) sb[sb.size()-1].valid = 1'b0;
        end
        expAddr = modelAddr(dx, dy);
        e.valid = !rst && mArmed && bl && modelInside(dx, dy);
        e.rom   = romData(10'(expAddr));
        e.flash = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        lastAddr = romAddr;
        if (!rst) begin
            checks++;
            if (romAddr !== 10'(expAddr)) begin
                failures++;
                $display("[TB] FAIL rom_addr draw=(%0d,%0d) got %0d want %0d", dx, dy, romAddr, expAddr);
            end
        end
        if (rst) begin
            mSx = 0; mSy = 0; mDir = 0; mFc = 0; mArmed = 1'b0;
        end else begin
            if (hf) mFc = 15;
            else if (fs && mFc > 0) mFc--;
            if (fs) begin
                mSx = int'(tankX); mSy = int'(tankY); mDir = int'(tankDir); mArmed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the output seen now belongs to the pixel driven two cycles ago.
    always @(negedge clk) begin : monitor
        entry_t     e;
        logic       expHit;
        logic [3:0] expIdx;
        if (sb.size() >= 3) begin
            e      = sb.pop_front();
            expHit = e.valid && (e.rom != 4'h0);
            expIdx = expHit ? (e.flash ? 4'h7 : e.rom) : 4'h0;
            checks += 2;
            if (pixHit !== expHit) begin
                failures++;
                $display("[TB] FAIL pix_hit got %b want %b", pixHit, expHit);
            end
            if (pixIndex !== expIdx) begin
                failures++;
                $display("[TB] FAIL pix_index got %0d want %0d", pixIndex, expIdx);
            end
        end
    end

    task automatic scanRow(input int x0, input int x1, input int y);
        for (int x = x0; x <= x1; x++) applyStimulus(x, y, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic newFrame();
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Reset clears the outputs, and nothing is drawn before the first frame boundary.
    task automatic test_reset();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks += 2;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit got %b want 0", pixHit); end
        if (pixIndex !== 4'h0) begin failures++; $display("[TB] FAIL reset_index got %0d want 0", pixIndex); end
        scanRow(0, 6, 0);
        checks++;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL unarmed_hit got %b want 0", pixHit); end
    endtask

    // Upright sprite at (100,50): top-left pixel reads ROM address 0 two cycles later.
    task automatic test_basic();
        tankX = 10'd100; tankY = 10'd50; tankDir = 2'd0;
        newFrame();
        applyStimulus(100, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd0) begin failures++; $display("[TB] FAIL basic_addr got %0d want 0", lastAddr); end
        applyStimulus(101, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (pixHit !== 1'b1) begin failures++; $display("[TB] FAIL basic_hit got %b want 1", pixHit); end
        if (pixIndex !== 4'd3) begin failures++; $display("[TB] FAIL basic_index got %0d want 3", pixIndex); end
        for (int y = 49; y <= 53; y++) scanRow(96, 135, y);
        scanRow(96, 135, 81);
        scanRow(96, 135, 82);
    endtask

    // All four facings, including the worked right/left address examples.
    task automatic test_rotation();
        tankX = 10'd0; tankY = 10'd0; tankDir = 2'd1;
        newFrame();
        applyStimulus(5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd835) begin failures++; $display("[TB] FAIL right_addr got %0d want 835", lastAddr); end
        scanRow(0, 34, 7);
        tankDir = 2'd3;
        newFrame();
        applyStimulus(5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd188) begin failures++; $display("[TB] FAIL left_addr got %0d want 188", lastAddr); end
        scanRow(0, 34, 12);
        tankDir = 2'd2;
        newFrame();
        scanRow(0, 34, 20);
        scanRow(0, 34, 31);
    endtask

    // Sprite hanging off the right edge: clipped, no wrap; blanking suppresses hits.
    task automatic test_edge();
        tankX = 10'd620; tankY = 10'd0; tankDir = 2'd0;
        newFrame();
        applyStimulus(639, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd19) begin failures++; $display("[TB] FAIL edge_addr got %0d want 19", lastAddr); end
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (pixHit !== 1'b1) begin failures++; $display("[TB] FAIL edge_hit got %b want 1", pixHit); end
        if (pixIndex !== 4'd2) begin failures++; $display("[TB] FAIL edge_index got %0d want 2", pixIndex); end
        applyStimulus(630, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL nowrap_hit got %b want 0", pixHit); end
        applyStimulus(631, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL blank_hit got %b want 0", pixHit); end
        scanRow(0, 12, 1);
        scanRow(610, 639, 3);
    endtask

    // Moving the tank mid-frame must not move the sprite until the next frame boundary.
    task automatic test_shadow();
        tankX = 10'd300;
        applyStimulus(625, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd69) begin failures++; $display("[TB] FAIL shadow_hold got %0d want 69", lastAddr); end
        scanRow(296, 310, 2);
        newFrame();
        applyStimulus(305, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd69) begin failures++; $display("[TB] FAIL shadow_new got %0d want 69", lastAddr); end
        scanRow(296, 310, 2);
    endtask

    // Damage flash: on/off per frame, expires after 15 frames, reload wins and restarts.
    task automatic test_flash();
        tankX = 10'd200; tankY = 10'd100; tankDir = 2'd0;
        newFrame();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        scanRow(200, 207, 100);
        checks++;
        if (pixIndex !== 4'h7) begin failures++; $display("[TB] FAIL flash_on got %0d want 7", pixIndex); end
        for (int f = 0; f < 15; f++) begin
            newFrame();
            scanRow(200, 207, 100);
        end
        checks++;
        if (pixIndex !== 4'h1) begin failures++; $display("[TB] FAIL flash_done got %0d want 1", pixIndex); end
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        scanRow(200, 207, 100);
        checks++;
        if (pixIndex !== 4'h7) begin failures++; $display("[TB] FAIL flash_reload got %0d want 7", pixIndex); end
        newFrame();
        scanRow(200, 207, 100);
        checks++;
        if (pixIndex !== 4'h1) begin failures++; $display("[TB] FAIL flash_even got %0d want 1", pixIndex); end
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        scanRow(200, 207, 100);
        checks++;
        if (pixIndex !== 4'h7) begin failures++; $display("[TB] FAIL flash_restart got %0d want 7", pixIndex); end
    endtask

    // Reset with a full pipeline (and competing frame_start/hit_flash) wipes everything.
    task automatic test_reset_midframe();
        scanRow(200, 205, 101);
        tankX = 10'd50; tankY = 10'd50; tankDir = 2'd2;
        applyStimulus(206, 101, 1'b1, 1'b1, 1'b1, 1'b1);
        checks += 2;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_hit got %b want 0", pixHit); end
        if (pixIndex !== 4'h0) begin failures++; $display("[TB] FAIL rst_mid_index got %0d want 0", pixIndex); end
        applyStimulus(207, 101, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pixHit !== 1'b0) begin failures++; $display("[TB] FAIL rst_flight_hit got %b want 0", pixHit); end
        applyStimulus(3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lastAddr !== 10'd67) begin failures++; $display("[TB] FAIL rst_shadow_addr got %0d want 67", lastAddr); end
        scanRow(0, 8, 0);
        tankX = 10'd0; tankY = 10'd0; tankDir = 2'd0;
        newFrame();
        applyStimulus(6, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(7, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (pixHit !== 1'b1) begin failures++; $display("[TB] FAIL rst_rearm_hit got %b want 1", pixHit); end
        if (pixIndex !== 4'h1) begin failures++; $display("[TB] FAIL rst_fc_clear got %0d want 1", pixIndex); end
    endtask

    // Random traffic around the sprite with occasional frame, hit and reset events.
    task automatic test_back_to_back();
        int dx, dy;
        bit fs, hf, rst;
        for (int i = 0; i < 600; i++) begin
            fs  = ($urandom_range(0, 24) == 0);
            hf  = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 150) == 0);
            if (fs) begin
                tankX   = 10'($urandom_range(0, 620));
                tankY   = 10'($urandom_range(0, 460));
                tankDir = 2'($urandom_range(0, 3));
            end
            dx = mSx + int'($urandom_range(0, 39)) - 4;
            dy = mSy + int'($urandom_range(0, 39)) - 4;
            if (dx < 0) dx = 0;
            if (dx > 639) dx = 639;
            if (dy < 0) dy = 0;
            if (dy > 479) dy = 479;
            applyStimulus(dx, dy, ($urandom_range(0, 7) != 0), fs, hf, rst);
        end
    endtask

    initial begin
        reset = 1'b1; frameStart = 1'b0; hitFlash = 1'b0; blank = 1'b0;
        tankX = '0; tankY = '0; tankDir = '0; drawX = '0; drawY = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_rotation();
        test_edge();
        test_shadow();
        test_flash();
        test_reset_midframe();
        test_back_to_back();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/tank_sprite_fetch.md
TANK_SPRITE_FETCH -- requirements
Module: tank_sprite_fetch

Interface
REQ-001 Param SPRITE_SIZE, 32, sprite edge length in pixels (power of two).
REQ-002 Param TRANSPARENT_INDEX, 4'h0, ROM index treated as background.
REQ-003 Param FLASH_INDEX, 4'h7, index substituted for visible pixels on flash-on frames.
REQ-004 Param FLASH_FRAMES, 15, frame count of a damage flash.
REQ-005 vga_clk  in  1  pixel clock; sole clock.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_start  in  1  one-cycle pulse at frame boundary.
REQ-008 tank_x, tank_y  in  10 each  sprite top-left screen coordinate.
REQ-009 tank_dir  in  2  facing: 0 up, 1 right, 2 down, 3 left.
REQ-010 hit_flash  in  1  one-cycle pulse that starts a damage flash.
REQ-011 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-012 blank  in  1  high when the pixel is in the active display area.
REQ-013 rom_addr  out  log2(SPRITE_SIZE^2)  sprite ROM address, combinational.
REQ-014 rom_q  in  4  ROM data, valid one cycle after rom_addr is presented.
REQ-015 pix_index  out  4  palette index fed to the downstream palette lookup.
REQ-016 pix_hit  out  1  high when pix_index is a visible tank pixel.

Function
REQ-017 tank_x/tank_y/tank_dir latched into shadow registers only on cycles with frame_start=1; all address math uses the shadows.
REQ-018 lx = DrawX - sx, ly = DrawY - sy, computed 11 bits wide; inside = both non-negative and both < SPRITE_SIZE.
REQ-019 Sprite partly past right/bottom screen edge: render the on-screen part only, no wrap-around.
REQ-020 With S = SPRITE_SIZE, (row,col) is: up (ly,lx); right (S-1-lx, ly); down (S-1-ly, S-1-lx); left (lx, S-1-ly).
REQ-021 rom_addr = row*S + col, driven every cycle, including when not inside.
REQ-022 Stage 1 registers inside AND blank. Stage 2 registers pix_index/pix_hit. Total latency from DrawX/DrawY/blank to outputs: exactly 2 cycles.
REQ-023 pix_hit = delayed(inside AND blank) AND rom_q != TRANSPARENT_INDEX.
REQ-024 pix_index = rom_q when pix_hit=1 and flash is off.
REQ-025 pix_index = FLASH_INDEX when pix_hit=1 and flash is on.
REQ-026 pix_index = TRANSPARENT_INDEX when pix_hit=0.
REQ-027 Flash counter fc (4 bits): hit_flash loads FLASH_FRAMES. Otherwise frame_start with fc>0 decrements fc. Flash is on when fc is odd.
REQ-028 hit_flash and frame_start in the same cycle: reload wins, no decrement.
REQ-029 hit_flash while a flash is active restarts the flash at FLASH_FRAMES.
REQ-030 frame_start and a changed tank_dir in the same cycle: the new direction applies from the next cycle.

Reset
REQ-031 Reset clears shadow x/y/dir to 0 (up), fc to 0, and both pipeline stages. On the next cycle pix_hit=0 and pix_index=TRANSPARENT_INDEX.
REQ-032 Reset mid-frame discards in-flight pixels. Output stays 0 until the first frame_start after Reset deasserts.
REQ-033 Reset has priority over frame_start and hit_flash in the same cycle.

Structure
REQ-034 Package tank_pkg holds: dir_t enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT) and the SPRITE_SIZE default constant.
REQ-035 Address transform is a combinational sub-module, tank_sprite_addr (inputs lx, ly, dir; output rom_addr). Pipeline and flash logic stay in tank_sprite_fetch.
REQ-036 The sprite ROM is external, a 1-cycle synchronous read.

Verification
REQ-037 Shadows latched (100,50,up) at frame_start; DrawX=100, DrawY=50, blank=1 -> rom_addr=0; two cycles later pix_index=rom_q(0), pix_hit=1 when rom_q!=0.
REQ-038 Shadows (0,0,right); DrawX=5, DrawY=3 -> rom_addr=(31-5)*32+3=835. Shadows (0,0,left), same DrawX/DrawY -> rom_addr=5*32+28=188.
REQ-039 Shadows (620,0,up); DrawX=639 -> inside, col 19. DrawX=0, DrawY=0 -> pix_hit=0, no wrap. blank=0 inside the sprite -> pix_hit=0 after 2 cycles.
REQ-040 tank_x changed mid-frame, no frame_start -> rom_addr unchanged until the next frame_start.
REQ-041 hit_flash -> fc=15, visible pixels read 4'h7. Each frame_start toggles flash on/off. After 15 frame_starts, normal indices return. hit_flash together with frame_start -> fc=15.
REQ-042 Reset asserted with the pipeline full -> next cycle pix_hit=0 and pix_index=0. fc=0 and shadows=0 afterwards.
